// File: rtl/fd_issue_ctrl.sv
// Front-end issue/stall controller for the 2-wide pipeline: FD/PC write enables, DX bubbles.
// Optional stall-cycle counter enabled with `define FD_STALL_CNT_EN.
module fd_issue_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        flush,
  input  logic        md_start,
  input  logic        load_use,
  input  logic        pair_dep,
  input  logic        fetch_slot1_valid,
  output logic        fd_we,
  output logic        fd_we2,
  output logic        pc_we,
  output logic        fd_flush,
  output logic        dx_slot0_nop,
  output logic        dx_slot1_nop,
  output logic [1:0]  state_out,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SPLIT   = 2'd1,
    MD_WAIT = 2'd2
  } state_e;

  localparam bit MD_MULTI = (MD_CYCLES > 1);
  // The md_start cycle is the first frozen cycle, so MD_WAIT lasts MD_CYCLES-1 cycles.
  localparam logic [CNT_W-1:0] MD_RELOAD = MD_MULTI ? CNT_W'(MD_CYCLES - 2) : '0;

  state_e           state_q, state_d;
  logic             ret_split_q, ret_split_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic fd_we_c, pc_we_c, fd_flush_c, nop0_c, nop1_c;

  always_comb begin
    state_d     = state_q;
    ret_split_d = ret_split_q;
    md_cnt_d    = md_cnt_q;
    fd_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    fd_flush_c  = 1'b0;
    nop0_c      = 1'b1;
    nop1_c      = 1'b1;
    case (state_q)
      RUN, SPLIT: begin
        if (flush) begin
          fd_flush_c = 1'b1;
          pc_we_c    = 1'b1;
          state_d    = RUN;
          if (md_start && MD_MULTI) begin
            state_d     = MD_WAIT;
            ret_split_d = 1'b0;
            md_cnt_d    = MD_RELOAD;
          end
        end else if (md_start) begin
          if (MD_MULTI) begin
            state_d     = MD_WAIT;
            ret_split_d = (state_q == SPLIT);
            md_cnt_d    = MD_RELOAD;
          end
        end else if (load_use) begin
          state_d = state_q;
        end else if (state_q == RUN && pair_dep) begin
          nop0_c  = 1'b0;
          state_d = SPLIT;
        end else begin
          // In SPLIT slot0 already went down the pipe; only slot1 issues now.
          fd_we_c = 1'b1;
          pc_we_c = 1'b1;
          nop0_c  = (state_q == SPLIT);
          nop1_c  = 1'b0;
          state_d = RUN;
        end
      end
      MD_WAIT: begin
        if (flush) begin
          fd_flush_c  = 1'b1;
          pc_we_c     = 1'b1;
          ret_split_d = 1'b0;
        end
        if (md_cnt_q == '0) begin
          state_d = (ret_split_q && !flush) ? SPLIT : RUN;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q     <= RUN;
      ret_split_q <= 1'b0;
      md_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ret_split_q <= ret_split_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  assign fd_we        = fd_we_c & ~ctrl_reset;
  assign fd_we2       = fd_we & fetch_slot1_valid;
  assign pc_we        = pc_we_c & ~ctrl_reset;
  assign fd_flush     = fd_flush_c | ctrl_reset;
  assign dx_slot0_nop = nop0_c | ctrl_reset;
  assign dx_slot1_nop = nop1_c | ctrl_reset;
  assign state_out    = state_q;

`ifdef FD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      stall_cnt_q <= '0;
    end else if (!pc_we && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

`ifndef SYNTHESIS
  // A second mult/div cannot enter execute while the front end is frozen for one.
  md_start_in_wait_a: assert property (@(posedge clock) disable iff (ctrl_reset)
    !(state_q == MD_WAIT && md_start));
`endif

endmodule

// File: tb/tb_fd_issue_ctrl.sv
// Bench for fd_issue_ctrl: two instances (MD_CYCLES 32 and 4) on shared inputs,
// checked cycle by cycle against a freeze-countdown reference model.
module tb_fd_issue_ctrl;

  localparam int MDC_A = 32;
  localparam int MDC_B = 4;

  logic clock;
  logic ctrl_reset, flush, md_start, load_use, pair_dep, fetch_slot1_valid;

  logic a_fd_we, a_fd_we2, a_pc_we, a_fd_flush, a_n0, a_n1;
  logic b_fd_we, b_fd_we2, b_pc_we, b_fd_flush, b_n0, b_n1;
  logic [1:0]  a_state, b_state;
  logic [15:0] a_stall, b_stall;
  logic [7:0]  a_obs, b_obs;

  assign a_obs = {a_fd_we, a_fd_we2, a_pc_we, a_fd_flush, a_n0, a_n1, a_state};
  assign b_obs = {b_fd_we, b_fd_we2, b_pc_we, b_fd_flush, b_n0, b_n1, b_state};

  fd_issue_ctrl #(.MD_CYCLES(MDC_A), .CNT_W(6)) u_dut_a (
    .clock(clock), .ctrl_reset(ctrl_reset), .flush(flush), .md_start(md_start),
    .load_use(load_use), .pair_dep(pair_dep), .fetch_slot1_valid(fetch_slot1_valid),
    .fd_we(a_fd_we), .fd_we2(a_fd_we2), .pc_we(a_pc_we), .fd_flush(a_fd_flush),
    .dx_slot0_nop(a_n0), .dx_slot1_nop(a_n1), .state_out(a_state), .stall_count(a_stall)
  );

  fd_issue_ctrl #(.MD_CYCLES(MDC_B), .CNT_W(6)) u_dut_b (
    .clock(clock), .ctrl_reset(ctrl_reset), .flush(flush), .md_start(md_start),
    .load_use(load_use), .pair_dep(pair_dep), .fetch_slot1_valid(fetch_slot1_valid),
    .fd_we(b_fd_we), .fd_we2(b_fd_we2), .pc_we(b_pc_we), .fd_flush(b_fd_flush),
    .dx_slot0_nop(b_n0), .dx_slot1_nop(b_n1), .state_out(b_state), .stall_count(b_stall)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: freeze cycles left, split pending, return-to-split, stall count.
  int m_freeze [2];
  bit m_split  [2];
  bit m_ret    [2];
  int m_stall  [2];

  logic [15:0] exp_q [$];
  logic [15:0] act, exp_v;
  logic [15:0] act_st [2];
  logic [15:0] exp_st [2];
  int n_tests, n_fail;

  task automatic step(input bit rst, input bit fl, input bit md, input bit lu,
                      input bit pd, input bit fv);
    logic [7:0] e [2];
    @(negedge clock);
    ctrl_reset = rst; flush = fl; md_start = md; load_use = lu;
    pair_dep = pd; fetch_slot1_valid = fv;
    #1;
    for (int d = 0; d < 2; d++) begin
      bit we, pc, fo, n0, n1;
      logic [1:0] st;
      int mdc;
      mdc = (d == 0) ? MDC_A : MDC_B;
      we = 0; pc = 0; fo = 0; n0 = 1; n1 = 1; st = 2'd0;
      if (rst) begin
        m_split[d] = 0; m_freeze[d] = 0; m_ret[d] = 0; m_stall[d] = 0;
      end
`ifdef FD_STALL_CNT_EN
      exp_st[d] = 16'(m_stall[d]);
`else
      exp_st[d] = 16'h0000;
`endif
      if (rst) begin
        fo = 1;
      end else if (m_freeze[d] > 0) begin
        st = 2'd2; pc = fl; fo = fl;
        if (fl) m_ret[d] = 0;
        m_freeze[d]--;
        if (m_freeze[d] == 0) m_split[d] = m_ret[d];
      end else begin
        st = m_split[d] ? 2'd1 : 2'd0;
        if (fl) begin
          pc = 1; fo = 1; m_split[d] = 0;
          if (md && mdc > 1) begin m_freeze[d] = mdc - 1; m_ret[d] = 0; end
        end else if (md) begin
          if (mdc > 1) begin m_freeze[d] = mdc - 1; m_ret[d] = m_split[d]; end
        end else if (lu) begin
          m_split[d] = m_split[d];
        end else if (!m_split[d] && pd) begin
          n0 = 0; m_split[d] = 1;
        end else begin
          we = 1; pc = 1; n0 = m_split[d]; n1 = 0; m_split[d] = 0;
        end
      end
      e[d] = {we, we & fv, pc, fo, n0, n1, st};
      if (!rst && !pc && m_stall[d] < 65535) m_stall[d]++;
    end
    exp_q.push_back({e[0], e[1]});
    act = {a_obs, b_obs};
    act_st[0] = a_stall;
    act_st[1] = b_stall;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(i < 3, 0, 0, 0, 0, 1);
      exp_v = exp_q.pop_front(); n_tests++;
      if (act !== exp_v) begin n_fail++; $display("FAIL reset_seq cyc%0d act=%h exp=%h", i, act, exp_v); end
      if (i < 3) begin
        n_tests++;
        if (act !== 16'h1C1C) begin n_fail++; $display("FAIL reset_forced act=%h exp=1c1c", act); end
      end
    end
    n_tests++;
    if (act !== 16'hE0E0) begin n_fail++; $display("FAIL reset_release act=%h exp=e0e0", act); end
  endtask

  task automatic test_pair_dep();
    logic [15:0] obs [3];
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, i == 0, 1);
      obs[i] = act;
      exp_v = exp_q.pop_front(); n_tests++;
      if (act !== exp_v) begin n_fail++; $display("FAIL pair_dep_seq cyc%0d act=%h exp=%h", i, act, exp_v); end
    end
    n_tests++;
    if (obs[0][15:8] !== 8'b0000_0100) begin n_fail++; $display("FAIL pair_dep_n act=%b exp=00000100", obs[0][15:8]); end
    n_tests++;
    if (obs[1][15:8] !== 8'b1110_1001) begin n_fail++; $display("FAIL pair_dep_n1 act=%b exp=11101001", obs[1][15:8]); end
    n_tests++;
    if (obs[2][15:8] !== 8'b1110_0000) begin n_fail++; $display("FAIL pair_dep_n2 act=%b exp=11100000", obs[2][15:8]); end
  endtask

  task automatic test_md32();
    int frozen;
    bit done;
    for (int i = 0; i < 2; i++) begin
      step(i == 0, 0, i == 1, 0, 0, 1);
      exp_v = exp_q.pop_front(); n_tests++;
      if (act !== exp_v) begin n_fail++; $display("FAIL md32_seq cyc%0d act=%h exp=%h", i, act, exp_v); end
    end
    frozen = 0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (act[13] === 1'b0) begin
        frozen++;
        step(0, 0, 0, 0, 0, 1);
        exp_v = exp_q.pop_front(); n_tests++;
        if (act !== exp_v) begin n_fail++; $display("FAIL md32_wait cyc%0d act=%h exp=%h", k, act, exp_v); end
      end else begin
        done = 1;
      end
    end
    n_tests++;
    if (!done || frozen != 32) begin n_fail++; $display("FAIL md32_len act=%0d exp=32 done=%0d", frozen, done); end
    n_tests++;
`ifdef FD_STALL_CNT_EN
    if (act_st[0] !== 16'd32) begin n_fail++; $display("FAIL md32_stall act=%0d exp=32", act_st[0]); end
`else
    if (act_st[0] !== 16'd0) begin n_fail++; $display("FAIL md32_stall act=%0d exp=0", act_st[0]); end
`endif
  endtask

  task automatic test_split_md4();
    int nb;
    nb = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, i == 1, 0, i == 0, 1);
      exp_v = exp_q.pop_front(); n_tests++;
      if (act !== exp_v) begin n_fail++; $display("FAIL split_md4_seq cyc%0d act=%h exp=%h", i, act, exp_v); end
      if (i >= 1 && i <= 4 && act[5] === 1'b0) nb++;
      if (i == 5) begin
        n_tests++;
        if (act[7:0] !== 8'b1110_1001) begin n_fail++; $display("FAIL split_md4_done act=%b exp=11101001", act[7:0]); end
      end
      if (i == 6) begin
        n_tests++;
        if (act[7:0] !== 8'b1110_0000) begin n_fail++; $display("FAIL split_md4_run act=%b exp=11100000", act[7:0]); end
      end
    end
    n_tests++;
    if (nb != 4) begin n_fail++; $display("FAIL split_md4_frozen act=%0d exp=4", nb); end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((m_freeze[0] > 0 || m_freeze[1] > 0 || m_split[0] || m_split[1]) && k < 100) begin
      step(0, 0, 0, 0, 0, 1);
      exp_v = exp_q.pop_front(); n_tests++;
      if (act !== exp_v) begin n_fail++; $display("FAIL idle_seq cyc%0d act=%h exp=%h", k, act, exp_v); end
      k++;
    end
    n_tests++;
    if (k >= 100) begin n_fail++; $display("FAIL idle_timeout act=%0d exp<100", k); end
  endtask

  task automatic test_flush_md();
    int nw;
    nw = 0;
    for (int i = 0; i < 34; i++) begin
      step(0, i == 27, i == 1, 0, i == 0, 1);
      exp_v = exp_q.pop_front(); n_tests++;
      if (act !== exp_v) begin n_fail++; $display("FAIL flush_md_seq cyc%0d act=%h exp=%h", i, act, exp_v); end
      if (i >= 2 && i <= 32 && act[9:8] === 2'd2) nw++;
      if (i == 27) begin
        n_tests++;
        if (act[13:12] !== 2'b11 || act[9:8] !== 2'd2) begin
          n_fail++; $display("FAIL flush_md_flush act=%b exp=pc1 fl1 st2", act[15:8]);
        end
      end
    end
    n_tests++;
    if (nw != 31) begin n_fail++; $display("FAIL flush_md_wait act=%0d exp=31", nw); end
    n_tests++;
    if (act[15:8] !== 8'b1110_0000) begin n_fail++; $display("FAIL flush_md_ret act=%b exp=11100000", act[15:8]); end
  endtask

  task automatic test_slot1_lu();
    logic [15:0] obs [4];
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, i == 2, i == 1, i != 0);
      obs[i] = act;
      exp_v = exp_q.pop_front(); n_tests++;
      if (act !== exp_v) begin n_fail++; $display("FAIL slot1_lu_seq cyc%0d act=%h exp=%h", i, act, exp_v); end
    end
    n_tests++;
    if (obs[0][15:8] !== 8'b1010_0000) begin n_fail++; $display("FAIL slot1_invalid act=%b exp=10100000", obs[0][15:8]); end
    n_tests++;
    if (obs[2][15:8] !== 8'b0000_1101) begin n_fail++; $display("FAIL split_load_use act=%b exp=00001101", obs[2][15:8]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      bit rst, fl, md;
      rst = ($urandom_range(0, 99) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      md  = (m_freeze[0] == 0 && m_freeze[1] == 0 && $urandom_range(0, 24) == 0);
      step(rst, fl, md, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      exp_v = exp_q.pop_front(); n_tests++;
      if (act !== exp_v) begin n_fail++; $display("FAIL random_obs cyc%0d act=%h exp=%h", i, act, exp_v); end
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (act_st[d] !== exp_st[d]) begin
          n_fail++; $display("FAIL random_stall dut%0d cyc%0d act=%0d exp=%0d", d, i, act_st[d], exp_st[d]);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    ctrl_reset = 1'b1; flush = 1'b0; md_start = 1'b0; load_use = 1'b0;
    pair_dep = 1'b0; fetch_slot1_valid = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_freeze[d] = 0; m_split[d] = 0; m_ret[d] = 0; m_stall[d] = 0;
    end
    test_reset();
    test_pair_dep();
    test_md32();
    test_split_md4();
    wait_idle();
    test_flush_md();
    wait_idle();
    test_slot1_lu();
    wait_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fd_issue_ctrl.md
Name: fd_issue_ctrl

Overview:
- Front-end issue/stall controller for the 2-wide pipeline.
- Drives the two write enables of the fetch/decode pipeline latch:
  - fd_we covers the common + slot0 field.
  - fd_we2 is slot1's enable, qualified inside the latch by fd_we.
- Also drives the PC write enable and the per-slot bubble injects into decode/execute.
- Sequences load-use stalls, intra-pair dependency splits, multi-cycle mult/div freezes and branch flushes.

Parameters:
- MD_CYCLES, 32: front-end freeze length in cycles for a mult/div, counting the md_start cycle. Legal range 1..2^CNT_W-1.
- CNT_W, 6: width of the mult/div wait counter.

Ports:
- clock, input, 1: sole clock, rising edge.
- ctrl_reset, input, 1: reset. Asynchronous, active-high.
- flush, input, 1: taken branch/jump resolved in execute; kill FD contents.
- md_start, input, 1: mult/div entering execute this cycle.
- load_use, input, 1: decode-stage load-use hazard on the current FD pair.
- pair_dep, input, 1: FD slot1 depends on FD slot0, or structural conflict; pair cannot dual-issue.
- fetch_slot1_valid, input, 1: fetch delivered a valid second instruction this cycle.
- fd_we, output, 1: FD latch enable, common/slot0 field.
- fd_we2, output, 1: FD latch enable, slot1 field.
- pc_we, output, 1: PC register write enable.
- fd_flush, output, 1: clear FD latch, i.e. load NOPs.
- dx_slot0_nop, output, 1: inject bubble in slot0 of the DX latch.
- dx_slot1_nop, output, 1: inject bubble in slot1 of the DX latch.
- state_out, output, 2: current state; RUN=0, SPLIT=1, MD_WAIT=2.
- stall_count, output, 16: stall-cycle counter (see Optional Feature).

Behaviour:
- Registers: state (2b), ret_state (1b: RUN/SPLIT), md_cnt (CNT_W).
- Reset, asynchronous: state=RUN, ret_state=RUN, md_cnt=0.
  - While ctrl_reset=1, outputs are forced: fd_we=0, fd_we2=0, pc_we=0, fd_flush=1, dx_slot0_nop=1, dx_slot1_nop=1.
  - Reset mid-MD_WAIT or mid-SPLIT abandons the operation; the first cycle after release is RUN.
- Outputs are combinational from state and inputs (Mealy). fd_we2 = fd_we & fetch_slot1_valid always.
- "Hold" means fd_we=0, pc_we=0.
- "Advance" means fd_we=1, pc_we=1.

RUN, in priority order:
1. flush: fd_flush=1, pc_we=1, fd_we=0, both nops=1. Next state RUN.
   - If md_start is also high, next state is MD_WAIT (if MD_CYCLES>1), ret_state=RUN.
2. md_start: hold, both nops=1.
   - If MD_CYCLES=1: next state RUN.
   - Else: md_cnt<=MD_CYCLES-2, ret_state<=RUN, next state MD_WAIT.
3. load_use: hold, both nops=1. Stay RUN.
4. pair_dep: hold, dx_slot0_nop=0, dx_slot1_nop=1 (slot0 issues alone). Next state SPLIT.
5. Otherwise: advance, both nops=0.

SPLIT (slot0 already issued; FD still holds the pair):
1. flush: same as RUN; next state RUN, split abandoned.
2. md_start: hold, both nops=1. Next state MD_WAIT with ret_state<=SPLIT (or SPLIT directly if MD_CYCLES=1).
3. load_use: hold, both nops=1. Stay SPLIT.
4. Otherwise: advance, dx_slot0_nop=1, dx_slot1_nop=0. Next state RUN. pair_dep is ignored in SPLIT.

MD_WAIT:
- Hold, both nops=1. load_use and pair_dep are ignored.
- If md_cnt==0: next state = ret_state. Else md_cnt decrements.
- flush in MD_WAIT: fd_flush=1, pc_we=1, ret_state<=RUN. The counter keeps running; a flush never shortens the freeze.
- md_start in MD_WAIT is illegal. Assertion in simulation; ignored in RTL.
- Total frozen cycles = MD_CYCLES exactly, including the md_start cycle.

Optional Feature:
- Macro: FD_STALL_CNT_EN.
- Defined:
  - stall_count increments by 1 on each clock edge at which pc_we=0 and ctrl_reset=0.
  - Saturates at 16'hFFFF.
  - Asynchronously reset to 0.
- Undefined: stall_count is tied to 16'h0000 and no counter flops are instantiated.

Test Plan:
- Reset held 3 cycles, then idle inputs with fetch_slot1_valid=1 -> during reset fd_flush=1, both nops=1, we=0. First cycle after release: fd_we=fd_we2=pc_we=1, state_out=0.
- pair_dep=1 for one cycle -> cycle N: dx_slot1_nop=1, fd_we=0, state_out goes to 1. Cycle N+1: dx_slot0_nop=1, fd_we=1, state_out back to 0.
- md_start pulse with MD_CYCLES=32 -> pc_we=0 for exactly 32 consecutive cycles, then 1. With FD_STALL_CNT_EN, stall_count=32.
- pair_dep, then md_start in the SPLIT cycle (MD_CYCLES=4) -> 4 frozen cycles, then one SPLIT-completion cycle (dx_slot0_nop=1, dx_slot1_nop=0), then RUN.
- flush during MD_WAIT at count 5 -> fd_flush=1 that cycle, freeze still ends on schedule, and the return is to RUN even if entered from SPLIT.
- fetch_slot1_valid=0 on an advance cycle -> fd_we=1, fd_we2=0. Load_use during SPLIT -> state stays 1 and both nops=1.
